// File: rtl/riscv_pkg.sv
// Shared RV32 constants: widths, reset PC, instruction field positions and base opcodes.
// Imported by the fetch unit, the decoder and the tests.
package riscv_pkg;

   localparam int unsigned XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   localparam int unsigned OP_LSB       = 0;
   localparam int unsigned OP_MSB       = 6;
   localparam int unsigned FUNCT3_LSB   = 12;
   localparam int unsigned FUNCT3_MSB   = 14;
   localparam int unsigned FUNCT7B5_BIT = 30;

   // Sized for responses still in flight across several back-to-back redirects.
   localparam int unsigned DROP_W = 8;

   localparam logic [6:0] OP_LW    = 7'b000_0011;
   localparam logic [6:0] OP_SW    = 7'b010_0011;
   localparam logic [6:0] OP_RTYPE = 7'b011_0011;
   localparam logic [6:0] OP_BEQ   = 7'b110_0011;
   localparam logic [6:0] OP_ITYPE = 7'b001_0011;
   localparam logic [6:0] OP_JAL   = 7'b110_1111;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: imem request/response, redirect from the controller and the decode
// handshake. The master side is the fetch unit.
interface instr_fetch_if #(
   parameter int unsigned XLEN = 32
) ();

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            redirect;
   logic [XLEN-1:0] redirect_target;
   logic            dec_valid;
   logic            dec_ready;
   logic [XLEN-1:0] dec_instr;
   logic [XLEN-1:0] dec_pc;
   logic [6:0]      dec_op;
   logic [2:0]      dec_funct3;
   logic            dec_funct7b5;

   modport master (
      output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_op, dec_funct3,
             dec_funct7b5,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_target, dec_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_op, dec_funct3,
             dec_funct7b5,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_target, dec_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; push and pop may coincide even when full. Flush wins over both.
module fetch_fifo #(
   parameter int unsigned Width = 64,
   parameter int unsigned Depth = 2,
   localparam int unsigned PtrW = $clog2(Depth),
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic [CntW-1:0]  count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rptr_q];
   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + PtrW'(1);
         if (do_pop)  rptr_d = rptr_q + PtrW'(1);
         count_d = count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      end else if (do_push && !flush_i) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   // The credit scheme upstream must never let a push land on a full FIFO without a pop.
   always_ff @(posedge clk) begin
      if (rst_n) assert (!(push_i && full_o && !pop_i && !flush_i));
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited in-order imem requests, PC-tagged response buffer,
// redirect flush with drop counting. Define FETCH_PERF_EN to add the fetch_stall_cnt counter.
module instr_fetch
   import riscv_pkg::*;
#(
   parameter int unsigned     XLEN     = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef FETCH_PERF_EN
   output logic [31:0] fetch_stall_cnt,
`endif
   instr_fetch_if.master bus
);

   localparam int unsigned   CntW   = $clog2(DEPTH + 1);
   localparam logic [CntW:0] DepthC = (CntW + 1)'(DEPTH);

   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic [CntW-1:0]   outst, buf_cnt;
   logic [XLEN-1:0]   tag_pc;
   logic [2*XLEN-1:0] buf_head, buf_out;
   logic              tag_full, tag_empty, buf_full, buf_empty;
   logic              credit_ok, accept, rsp_keep, pop;
   logic              unused_sigs;

   assign credit_ok = ({1'b0, outst} + {1'b0, buf_cnt}) < DepthC;
   assign bus.imem_req_valid = rst_n && !bus.redirect && credit_ok;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign accept   = bus.imem_req_valid && bus.imem_req_ready;
   assign rsp_keep = bus.imem_rsp_valid && (drop_q == '0);
   assign pop      = bus.dec_valid && bus.dec_ready && !bus.redirect;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      drop_d     = drop_q;
      if (bus.redirect) begin
         fetch_pc_d = {bus.redirect_target[XLEN-1:2], 2'b00};
         drop_d     = drop_q + DROP_W'(outst) - DROP_W'(bus.imem_rsp_valid);
      end else begin
         if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
         if (bus.imem_rsp_valid && drop_q != '0) drop_d = drop_q - DROP_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         drop_q     <= drop_d;
      end
   end

   // One tag per live request, so the tag count doubles as the outstanding counter.
   fetch_fifo #(
      .Width (XLEN),
      .Depth (DEPTH)
   ) u_tag_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (bus.redirect),
      .push_i  (accept),
      .wdata_i (fetch_pc_q),
      .pop_i   (rsp_keep && !bus.redirect),
      .rdata_o (tag_pc),
      .count_o (outst),
      .full_o  (tag_full),
      .empty_o (tag_empty)
   );

   fetch_fifo #(
      .Width (2 * XLEN),
      .Depth (DEPTH)
   ) u_buf_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (bus.redirect),
      .push_i  (rsp_keep && !bus.redirect),
      .wdata_i ({bus.imem_rsp_data, tag_pc}),
      .pop_i   (pop),
      .rdata_o (buf_head),
      .count_o (buf_cnt),
      .full_o  (buf_full),
      .empty_o (buf_empty)
   );

   assign buf_out          = buf_empty ? '0 : buf_head;
   assign bus.dec_valid    = !buf_empty;
   assign bus.dec_instr    = buf_out[2*XLEN-1:XLEN];
   assign bus.dec_pc       = buf_out[XLEN-1:0];
   assign bus.dec_op       = buf_out[XLEN+OP_MSB:XLEN+OP_LSB];
   assign bus.dec_funct3   = buf_out[XLEN+FUNCT3_MSB:XLEN+FUNCT3_LSB];
   assign bus.dec_funct7b5 = buf_out[XLEN+FUNCT7B5_BIT];

   assign unused_sigs = ^{tag_full, tag_empty, buf_full, bus.redirect_target[1:0]};

`ifdef FETCH_PERF_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (bus.dec_ready && !bus.dec_valid && !bus.redirect && stall_cnt_q != '1) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign fetch_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and random bench for instr_fetch: in-order memory model with per-request latency and
// an epoch-based reference of which words reach decode after redirects and resets.
module tb_instr_fetch;
   import riscv_pkg::*;

   localparam int unsigned Depth   = 2;
   localparam logic [31:0] ResetPc = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   instr_fetch_if #(.XLEN(32)) bus_if ();

`ifdef FETCH_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] stall_base;
`endif

   instr_fetch #(
      .XLEN     (32),
      .RESET_PC (ResetPc),
      .DEPTH    (Depth)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
`ifdef FETCH_PERF_EN
      .fetch_stall_cnt (stall_cnt),
`endif
      .bus             (bus_if.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } ent_t;

   req_t        inflight[$];
   ent_t        fifo_m[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          epoch = 0;
   int          issued = 0;
   int          popped = 0;
   int          lat = 1;
   logic [31:0] exp_pc = ResetPc;
   bit          nop_mem = 1'b1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (nop_mem) return 32'h0000_0013;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0033;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_req_valid"}, 32'(bus_if.imem_req_valid), 32'd0);
      check({tag, "_dec_valid"}, 32'(bus_if.dec_valid), 32'd0);
      check({tag, "_dec_instr"}, bus_if.dec_instr, 32'd0);
      check({tag, "_dec_pc"}, bus_if.dec_pc, 32'd0);
   endtask

   // Reset clears both the fetch unit and the memory's pending responses.
   task automatic model_reset();
      inflight.delete();
      fifo_m.delete();
      issued = 0;
      popped = 0;
      exp_pc = ResetPc;
      epoch++;
   endtask

   // Called at posedge+1: drive one cycle, compare mid-cycle, advance the model past the edge.
   task automatic cycle(input bit red, input logic [31:0] tgt, input bit dready, input bit rready);
      ent_t h;
      req_t r;
      bit   exp_rv, exp_dv, rsp, keep, acc, pop;
      bus_if.redirect        = red;
      bus_if.redirect_target = tgt;
      bus_if.dec_ready       = dready;
      bus_if.imem_req_ready  = rready;
      rsp = 1'b0;
      if (inflight.size() > 0) rsp = (inflight[0].due <= cyc);
      bus_if.imem_rsp_valid = rsp;
      bus_if.imem_rsp_data  = rsp ? mem_word(inflight[0].addr) : $urandom();
      @(negedge clk);
      exp_rv = !red && ((issued - popped) < int'(Depth));
      check("req_valid", 32'(bus_if.imem_req_valid), 32'(exp_rv));
      if (exp_rv) check("req_addr", bus_if.imem_req_addr, exp_pc);
      exp_dv = (fifo_m.size() > 0);
      check("dec_valid", 32'(bus_if.dec_valid), 32'(exp_dv));
      if (exp_dv) begin
         h = fifo_m[0];
         check("dec_pc", bus_if.dec_pc, h.pc);
         check("dec_instr", bus_if.dec_instr, h.word);
         check("dec_op", 32'(bus_if.dec_op), {25'd0, h.word[6:0]});
         check("dec_funct3", 32'(bus_if.dec_funct3), {29'd0, h.word[14:12]});
         check("dec_funct7b5", 32'(bus_if.dec_funct7b5), {31'd0, h.word[30]});
      end
      acc = exp_rv && rready;
      pop = exp_dv && dready && !red;
      @(posedge clk);
      #1;
      keep = 1'b0;
      if (rsp) begin
         r    = inflight.pop_front();
         keep = (r.epoch == epoch) && !red;
      end
      if (red) begin
         epoch++;
         fifo_m.delete();
         issued = 0;
         popped = 0;
         exp_pc = {tgt[31:2], 2'b00};
      end else begin
         if (pop) begin
            void'(fifo_m.pop_front());
            popped++;
         end
         if (keep) fifo_m.push_back('{pc: r.addr, word: mem_word(r.addr)});
         if (acc) begin
            inflight.push_back('{addr: exp_pc, epoch: epoch, due: cyc + lat});
            issued++;
            exp_pc += 32'd4;
         end
      end
      cyc++;
   endtask

   initial begin
      bus_if.imem_req_ready  = 1'b0;
      bus_if.imem_rsp_valid  = 1'b0;
      bus_if.imem_rsp_data   = '0;
      bus_if.redirect        = 1'b0;
      bus_if.redirect_target = '0;
      bus_if.dec_ready       = 1'b0;
      #1;
      reset_checks("por");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      cyc = 0;

      // NOP stream at latency 1, then decode backpressure and release
      nop_mem = 1'b1;
      lat = 1;
      repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1);
      repeat (6) cycle(1'b0, 32'h0, 1'b0, 1'b1);
      repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);

      // Two requests in flight at latency 3 are discarded by a redirect to 0x100
      nop_mem = 1'b0;
      lat = 3;
      cycle(1'b1, 32'h200, 1'b1, 1'b1);
      repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b1);
      cycle(1'b1, 32'h100, 1'b1, 1'b1);
      repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b1);

      // Unaligned target, then back-to-back redirects
      lat = 1;
      cycle(1'b1, 32'h102, 1'b1, 1'b1);
      repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b1);
      cycle(1'b1, 32'h40, 1'b1, 1'b1);
      cycle(1'b1, 32'h80, 1'b1, 1'b1);
      repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);

      // PC wrap through zero
      cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
      repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1);

`ifdef FETCH_PERF_EN
      cycle(1'b1, 32'h300, 1'b1, 1'b1);
      stall_base = stall_cnt;
      repeat (5) cycle(1'b0, 32'h0, 1'b1, 1'b0);
      check("stall_cnt_delta", stall_cnt - stall_base, 32'd5);
      repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b1);
`endif

      // Asynchronous reset with responses pending
      lat = 3;
      repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b1);
      rst_n = 1'b0;
      bus_if.imem_rsp_valid = 1'b0;
      bus_if.redirect       = 1'b0;
      #1;
      reset_checks("mid_reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      lat = 1;
      repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1);

      // Random traffic: latency, readiness, redirects and targets
      repeat (400) begin
         lat = $urandom_range(1, 4);
         cycle(($urandom_range(0, 15) == 0), $urandom(), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 3) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
